jpeg_pixel_sink: RTL and testbench

- Consumer end of the jpeg_core pixel output port (outport_valid/accept, width/height/x/y/r/g/b).
- Applies backpressure via a small FIFO and repacks each pixel into the 88-bit ring word {width,height,x,y,r,g,b} for the trace/FSB side (valid/ready).
- Tracks frame boundaries; per frame it produces a pixel count, a checksum, and sticky error flags.
- Lets jpeg_core run with real outport_accept instead of a tied-high accept.

---
 rtl/jpeg_sink_pkg.sv | 17 +
 rtl/jpeg_pixel_fifo.sv | 35 +++
 rtl/jpeg_pixel_sink.sv | 79 +++++++
 tb/tb_jpeg_pixel_sink.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jpeg_sink_pkg.sv
// jpeg_sink_pkg: shared types for the jpeg pixel sink (ring word layout, frame FSM states)
package jpeg_sink_pkg;
  localparam int RING_W = 88;
  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  function automatic logic [31:0] rgb_word(input pixel_t p);
    return {8'h0, p.r, p.g, p.b};
  endfunction
endpackage

// File: rtl/jpeg_pixel_fifo.sv
// jpeg_pixel_fifo: small synchronous FIFO, head word shown combinationally, zero when empty
module jpeg_pixel_fifo #(
  parameter int WIDTH = 88,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // extra pointer bit distinguishes full from empty when the indices match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/jpeg_pixel_sink.sv
// jpeg_pixel_sink: buffers jpeg_core pixels into 88-bit ring words and tracks per-frame count,
// checksum and sticky range/size errors
module jpeg_pixel_sink
  import jpeg_sink_pkg::*;
#(
  parameter int DEPTH_P  = 4,
  parameter int RING_W_P = 88
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pix_valid_i,
  input  logic [15:0]         pix_width_i,
  input  logic [15:0]         pix_height_i,
  input  logic [15:0]         pix_x_i,
  input  logic [15:0]         pix_y_i,
  input  logic [7:0]          pix_r_i,
  input  logic [7:0]          pix_g_i,
  input  logic [7:0]          pix_b_i,
  output logic                pix_accept_o,
  output logic                v_o,
  output logic [RING_W_P-1:0] data_o,
  input  logic                ready_i,
  output logic                frame_done_o,
  output logic [31:0]         frame_pixels_o,
  output logic [31:0]         checksum_o,
  output logic                range_err_o,
  output logic                size_err_o
);
  pixel_t pix;
  state_t state, state_nxt;
  logic full, empty, acc, start;
  logic [15:0] w_q, h_q, cur_w, cur_h;
  logic [31:0] total_q, prod, pixels_inc;
  assign pix = {pix_width_i, pix_height_i, pix_x_i, pix_y_i, pix_r_i, pix_g_i, pix_b_i};
  jpeg_pixel_fifo #(.WIDTH(RING_W_P), .DEPTH(DEPTH_P)) u_fifo (
    .clk(clk_i), .rst_n(rst_i), .push(pix_valid_i), .pop(ready_i),
    .wdata(pix), .rdata(data_o), .full(full), .empty(empty)
  );
  assign pix_accept_o = !full;
  assign v_o          = !empty;
  assign frame_done_o = state == DONE;
  assign acc          = pix_valid_i && pix_accept_o;
  assign start        = acc && state != ACTIVE;
  // the first pixel of a frame is checked against its own size, later ones against the latched size
  assign cur_w        = start ? pix_width_i : w_q;
  assign cur_h        = start ? pix_height_i : h_q;
  assign prod         = {16'h0, pix_width_i} * {16'h0, pix_height_i};
  assign pixels_inc   = frame_pixels_o + 32'd1;
  always_comb
    state_nxt = start ? (prod <= 32'd1 ? DONE : ACTIVE) :
                state == DONE ? IDLE :
                (acc && pixels_inc == total_q) ? DONE : state;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state          <= IDLE;
      w_q            <= '0;
      h_q            <= '0;
      total_q        <= '0;
      frame_pixels_o <= '0;
      checksum_o     <= '0;
      range_err_o    <= 1'b0;
      size_err_o     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        w_q            <= pix_width_i;
        h_q            <= pix_height_i;
        total_q        <= prod;
        frame_pixels_o <= 32'd1;
        checksum_o     <= rgb_word(pix);
      end else if (acc) begin
        frame_pixels_o <= pixels_inc;
        checksum_o     <= checksum_o + rgb_word(pix);
      end
      if (acc && (pix_x_i >= cur_w || pix_y_i >= cur_h)) range_err_o <= 1'b1;
      if (start ? (pix_width_i == '0 || pix_height_i == '0)
                : (acc && (pix_width_i != w_q || pix_height_i != h_q))) size_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_jpeg_pixel_sink.sv
// tb_jpeg_pixel_sink: directed frames against a queue/frame-level model checked every cycle
module tb_jpeg_pixel_sink;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, ready = 1'b0;
  logic [15:0] w = '0, h = '0, x = '0, y = '0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic pix_accept, v, frame_done, range_err, size_err;
  logic [87:0] data;
  logic [31:0] frame_pixels, checksum;
  int vectors = 0, miscompares = 0;
  logic [87:0] q[$];
  bit in_frame = 0, done_exp = 0, done_next, in_x, out_x, rerr = 0, serr = 0;
  logic [15:0] lw, lh;
  logic [31:0] total, cnt = 0, sum = 0, rgbw;

  always #5 clk = ~clk;

  jpeg_pixel_sink #(.DEPTH_P(DEPTH), .RING_W_P(88)) dut (
    .clk_i(clk), .rst_i(rst_n), .pix_valid_i(pix_valid),
    .pix_width_i(w), .pix_height_i(h), .pix_x_i(x), .pix_y_i(y),
    .pix_r_i(r), .pix_g_i(g), .pix_b_i(b), .pix_accept_o(pix_accept),
    .v_o(v), .data_o(data), .ready_i(ready), .frame_done_o(frame_done),
    .frame_pixels_o(frame_pixels), .checksum_o(checksum),
    .range_err_o(range_err), .size_err_o(size_err)
  );

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      in_frame = 0; done_exp = 0; cnt = 0; sum = 0; rerr = 0; serr = 0;
      chk("rst_v", v, 0);
      chk("rst_data", data, 0);
      chk("rst_accept", pix_accept, 1);
      chk("rst_done", frame_done, 0);
      chk("rst_pixels", frame_pixels, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_errs", {range_err, size_err}, 0);
    end else begin
      chk("accept", pix_accept, q.size() < DEPTH);
      chk("valid", v, q.size() != 0);
      if (q.size() != 0) chk("data", data, q[0]);
      chk("frame_done", frame_done, done_exp);
      chk("pixels", frame_pixels, cnt);
      chk("checksum", checksum, sum);
      chk("range_err", range_err, rerr);
      chk("size_err", size_err, serr);
      in_x = pix_valid && q.size() < DEPTH;
      out_x = ready && q.size() != 0;
      done_next = 0;
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back({w, h, x, y, r, g, b});
        rgbw = {8'h0, r, g, b};
        if (!in_frame) begin
          lw = w; lh = h; total = 32'(w) * 32'(h);
          cnt = 1; sum = rgbw;
          if (w == 0 || h == 0) serr = 1;
          if (x >= w || y >= h) rerr = 1;
          if (total <= 1) done_next = 1; else in_frame = 1;
        end else begin
          if (w != lw || h != lh) serr = 1;
          if (x >= lw || y >= lh) rerr = 1;
          cnt++; sum += rgbw;
          if (cnt == total) begin in_frame = 0; done_next = 1; end
        end
      end
      done_exp = done_next;
    end
  end

  task automatic send(input logic [15:0] sw, sh, sx, sy, input logic [23:0] rgb);
    int n = 0;
    bit ok;
    w = sw; h = sh; x = sx; y = sy; {r, g, b} = rgb; pix_valid = 1;
    do begin
      @(negedge clk); ok = pix_accept;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: accept stayed 0, required 1");
    end
    pix_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words left, required 0", q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    ready = 1;
    send(2, 2, 0, 0, 24'h010203);
    send(2, 2, 1, 0, 24'h040506);
    send(2, 2, 0, 1, 24'h070809);
    send(2, 2, 1, 1, 24'h0A0B0C);
    @(negedge clk);
    chk("t1_done", frame_done, 1);
    chk("t1_pixels", frame_pixels, 4);
    chk("t1_checksum", checksum, 32'h00161A1E);
    chk("t1_errs", {range_err, size_err}, 0);
    drain();
    ready = 0;
    fork
      for (int i = 0; i < 6; i++) send(3, 2, 16'(i % 3), 16'(i / 3), 24'(32'h101010 * (i + 1)));
      begin repeat (8) @(posedge clk); #1 ready = 1; end
    join
    drain();
    chk("t2_pixels", frame_pixels, 6);
    send(4, 1, 0, 0, 24'h000001);
    send(4, 1, 5, 0, 24'h000002);
    send(4, 1, 2, 0, 24'h000003);
    send(4, 1, 3, 0, 24'h000004);
    @(negedge clk);
    chk("t4_done", frame_done, 1);
    chk("t4_range", range_err, 1);
    chk("t4_size", size_err, 0);
    drain();
    send(4, 1, 0, 0, 24'h000001);
    send(8, 1, 1, 0, 24'h000001);
    send(4, 1, 2, 0, 24'h000001);
    send(4, 1, 3, 0, 24'h000001);
    @(negedge clk);
    chk("t5_done", frame_done, 1);
    chk("t5_size", size_err, 1);
    chk("t5_pixels", frame_pixels, 4);
    drain();
    send(0, 1, 0, 0, 24'h112233);
    @(negedge clk);
    chk("t6_done", frame_done, 1);
    chk("t6_pixels", frame_pixels, 1);
    chk("t6_checksum", checksum, 32'h00112233);
    drain();
    ready = 0;
    send(2, 2, 0, 0, 24'h0000AA);
    send(2, 2, 1, 0, 24'h0000BB);
    #2 rst_n = 0;
    #1;
    chk("t7_v", v, 0);
    chk("t7_pixels", frame_pixels, 0);
    chk("t7_checksum", checksum, 0);
    chk("t7_errs", {range_err, size_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; ready = 1;
    send(1, 1, 0, 0, 24'h0A0B0C);
    @(negedge clk);
    chk("t7_done", frame_done, 1);
    chk("t7_pixels1", frame_pixels, 1);
    chk("t7_checksum1", checksum, 32'h000A0B0C);
    drain();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
